interrupt_timer: RTL and testbench

- Memory-mapped peripheral timer that produces the IRQ level consumed by the Control decoder.
- Control takes the exception path, PCSrc = 3'b100, when IRQ=1 and PCK=0.
- Sits on the data-memory bus beside the data RAM. Software programs the reload and counter values, enables the timer, and clears the interrupt status in the handler.
- Also provides a free-running cycle counter (systick) for software timing.

---
 rtl/interrupt_timer_pkg.sv | 22 ++
 rtl/interrupt_timer_if.sv | 12 +
 rtl/interrupt_timer_timer_counter.sv | 47 ++++
 rtl/interrupt_timer.sv | 91 +++++++++
 tb/tb_interrupt_timer.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/interrupt_timer_pkg.sv
// Shared constants for the interrupt timer peripheral: base address,
// register offsets inside the 32-byte window and TCON bit positions.
package interrupt_timer_pkg;

   localparam logic [31:0] IT_BASE_ADDR = 32'h4000_0000;
   localparam int          IT_TCON_W    = 3;

   localparam logic [4:0] TH_OFS      = 5'h00;
   localparam logic [4:0] TL_OFS      = 5'h04;
   localparam logic [4:0] TCON_OFS    = 5'h08;
   localparam logic [4:0] SYSTICK_OFS = 5'h14;

   localparam int EN_BIT = 0;
   localparam int IE_BIT = 1;
   localparam int IS_BIT = 2;

   // True when addr falls inside the 32-byte register window at base.
   function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
      return addr[31:5] == base[31:5];
   endfunction

endpackage

// File: rtl/interrupt_timer_if.sv
// Data-memory bus slice seen by the timer: strobes, address, write data and
// the combinational read data returned by the peripheral.
interface interrupt_timer_if;
   logic        rd;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output rd, wr, addr, wdata, input rdata);
   modport slave  (input rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/interrupt_timer_timer_counter.sv
// TL up-counter with TH reload. overflow_pulse_o is high during any enabled
// cycle in which TL sits at all-ones, even if software overwrites TL that
// cycle: the overflow still happened, only the reload is suppressed.
module timer_counter (
   input  logic        clk,
   input  logic        reset,
   input  logic        en_i,
   input  logic        th_we_i,
   input  logic        tl_we_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] th_o,
   output logic [31:0] tl_o,
   output logic        overflow_pulse_o
);

   logic [31:0] th_q, th_d;
   logic [31:0] tl_q, tl_d;

   assign overflow_pulse_o = en_i && (tl_q == 32'hFFFF_FFFF);

   // Next TL/TH: software write wins over counting; reload uses the old TH.
   always_comb begin
      th_d = th_q;
      tl_d = tl_q;
      if (th_we_i) th_d = wdata_i;
      if (tl_we_i) begin
         tl_d = wdata_i;
      end else if (en_i) begin
         tl_d = overflow_pulse_o ? th_q : tl_q + 32'd1;
      end
   end

   // Register update with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         th_q <= '0;
         tl_q <= '0;
      end else begin
         th_q <= th_d;
         tl_q <= tl_d;
      end
   end

   assign th_o = th_q;
   assign tl_o = tl_q;

endmodule

// File: rtl/interrupt_timer.sv
// Memory-mapped interrupt timer: address decode, TCON, SYSTICK, rdata mux
// and the registered IRQ level for Control.
//
// state   | meaning
// IDLE    | EN=0, TL holds
// COUNT   | EN=1, IS=0, TL counts toward overflow
// PENDING | IS=1, irqout follows IE; counting continues while EN=1
// Leaving PENDING only happens through a TCON write with wdata[2]=0.
module interrupt_timer
   import interrupt_timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = IT_BASE_ADDR,
   parameter int          TCON_W    = IT_TCON_W
) (
   input  logic               clk,
   input  logic               reset,
   interrupt_timer_if.slave   bus,
   output logic               irqout
);

   logic              win;
   logic [4:0]        ofs;
   logic              wr_th, wr_tl, wr_tcon;
   logic [31:0]       th, tl;
   logic              overflow;
   logic [TCON_W-1:0] tcon_q, tcon_d;
   logic              irq_q, irq_d;
   logic [31:0]       systick_q;
   logic [31:0]       rdata_mux;
   logic              unused_addr_lsb;

   assign win             = in_window(bus.addr, BASE_ADDR);
   assign ofs             = {bus.addr[4:2], 2'b00};
   assign unused_addr_lsb = ^bus.addr[1:0];

   assign wr_th   = bus.wr && win && (ofs == TH_OFS);
   assign wr_tl   = bus.wr && win && (ofs == TL_OFS);
   assign wr_tcon = bus.wr && win && (ofs == TCON_OFS);

   timer_counter u_counter (
      .clk              (clk),
      .reset            (reset),
      .en_i             (tcon_q[EN_BIT]),
      .th_we_i          (wr_th),
      .tl_we_i          (wr_tl),
      .wdata_i          (bus.wdata),
      .th_o             (th),
      .tl_o             (tl),
      .overflow_pulse_o (overflow)
   );

   // TCON next state; an overflow with IE set forces IS so a same-cycle
   // software clear cannot swallow the interrupt.
   always_comb begin
      tcon_d = tcon_q;
      if (wr_tcon) tcon_d = bus.wdata[TCON_W-1:0];
      if (overflow && tcon_q[IE_BIT]) tcon_d[IS_BIT] = 1'b1;
      irq_d = tcon_d[IS_BIT] & tcon_d[IE_BIT];
   end

   // TCON, IRQ flop and free-running SYSTICK.
   always_ff @(posedge clk) begin
      if (reset) begin
         tcon_q    <= '0;
         irq_q     <= 1'b0;
         systick_q <= '0;
      end else begin
         tcon_q    <= tcon_d;
         irq_q     <= irq_d;
         systick_q <= systick_q + 32'd1;
      end
   end

   // Zero-latency read mux; shows pre-write values on simultaneous rd/wr.
   always_comb begin
      rdata_mux = '0;
      if (bus.rd && win) begin
         case (ofs)
            TH_OFS:      rdata_mux = th;
            TL_OFS:      rdata_mux = tl;
            TCON_OFS:    rdata_mux = {{(32-TCON_W){1'b0}}, tcon_q};
            SYSTICK_OFS: rdata_mux = systick_q;
            default:     rdata_mux = '0;
         endcase
      end
   end

   assign bus.rdata = rdata_mux;
   assign irqout    = irq_q;

endmodule

// File: tb/tb_interrupt_timer.sv
// Directed bench for interrupt_timer: expected values are queued when a
// check is issued and popped when the DUT output is sampled.
module tb_interrupt_timer;
   import interrupt_timer_pkg::*;

   localparam logic [31:0] A_TH   = 32'h4000_0000;
   localparam logic [31:0] A_TL   = 32'h4000_0004;
   localparam logic [31:0] A_TCON = 32'h4000_0008;
   localparam logic [31:0] A_1C   = 32'h4000_001C;
   localparam logic [31:0] A_ST   = 32'h4000_0014;
   localparam logic [31:0] A_OUT  = 32'h4000_0020;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic irqout;
   logic [31:0] st_model;
   logic [31:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   interrupt_timer_if bus_if ();

   interrupt_timer #(.BASE_ADDR(32'h4000_0000), .TCON_W(3)) dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus_if),
      .irqout (irqout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) st_model <= reset ? 32'd0 : st_model + 32'd1;

   task automatic compare(input string tag, input logic [31:0] obs);
      logic [31:0] exp;
      exp = exp_q.pop_front();
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      exp_q.push_back(exp);
      bus_if.addr = a;
      bus_if.rd   = 1'b1;
      #1;
      compare(tag, bus_if.rdata);
      bus_if.rd   = 1'b0;
   endtask

   task automatic irq_chk(input string tag, input logic e);
      exp_q.push_back({31'b0, e});
      compare(tag, {31'b0, irqout});
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr_op(input logic [31:0] a, input logic [31:0] d);
      bus_if.addr  = a;
      bus_if.wdata = d;
      bus_if.wr    = 1'b1;
      @(negedge clk);
      bus_if.wr    = 1'b0;
   endtask

   initial begin
      bus_if.rd    = 1'b0;
      bus_if.wr    = 1'b0;
      bus_if.addr  = '0;
      bus_if.wdata = '0;

      // 1: reset values and SYSTICK start
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      rd_chk("rst_th", A_TH, 32'h0);
      rd_chk("rst_tl", A_TL, 32'h0);
      rd_chk("rst_tcon", A_TCON, 32'h0);
      irq_chk("rst_irq", 1'b0);
      cyc(1);
      rd_chk("systick_first", A_ST, 32'd1);
      irq_chk("rst_irq2", 1'b0);

      // 2: first overflow
      wr_op(A_TH, 32'hFFFF_FFF0);
      wr_op(A_TL, 32'hFFFF_FFFE);
      wr_op(A_TCON, 32'h3);
      rd_chk("t2_tl_start", A_TL, 32'hFFFF_FFFE);
      rd_chk("t2_tcon_start", A_TCON, 32'h3);
      irq_chk("t2_irq_start", 1'b0);
      cyc(1);
      rd_chk("t2_tl_max", A_TL, 32'hFFFF_FFFF);
      irq_chk("t2_irq_max", 1'b0);
      cyc(1);
      rd_chk("t2_tl_reload", A_TL, 32'hFFFF_FFF0);
      rd_chk("t2_tcon_pend", A_TCON, 32'h7);
      irq_chk("t2_irq_set", 1'b1);

      // 3: clear and wait 16 cycles for the next overflow
      wr_op(A_TCON, 32'h3);
      rd_chk("t3_tl", A_TL, 32'hFFFF_FFF1);
      rd_chk("t3_tcon_clr", A_TCON, 32'h3);
      irq_chk("t3_irq_clr", 1'b0);
      cyc(14);
      rd_chk("t3_tl_max", A_TL, 32'hFFFF_FFFF);
      irq_chk("t3_irq_max", 1'b0);
      cyc(1);
      rd_chk("t3_tl_reload", A_TL, 32'hFFFF_FFF0);
      rd_chk("t3_tcon_pend", A_TCON, 32'h7);
      irq_chk("t3_irq_set", 1'b1);

      // 4: clear write landing on the overflow edge
      cyc(15);
      rd_chk("t4_tl_max", A_TL, 32'hFFFF_FFFF);
      wr_op(A_TCON, 32'h3);
      rd_chk("t4_tcon_kept", A_TCON, 32'h7);
      rd_chk("t4_tl_reload", A_TL, 32'hFFFF_FFF0);
      irq_chk("t4_irq_kept", 1'b1);

      // 5: TL write wins over reload on the overflow edge
      wr_op(A_TCON, 32'h3);
      wr_op(A_TH, 32'h0);
      rd_chk("t5_th", A_TH, 32'h0);
      rd_chk("t5_tcon_clr", A_TCON, 32'h3);
      irq_chk("t5_irq_clr", 1'b0);
      cyc(13);
      rd_chk("t5_tl_max", A_TL, 32'hFFFF_FFFF);
      wr_op(A_TL, 32'h0000_1234);
      rd_chk("t5_tl_written", A_TL, 32'h0000_1234);
      rd_chk("t5_tcon_pend", A_TCON, 32'h7);
      irq_chk("t5_irq_set", 1'b1);

      // 6: read-only and out-of-window writes
      wr_op(A_TCON, 32'h0);
      rd_chk("t6_tl_hold", A_TL, 32'h0000_1235);
      irq_chk("t6_irq_off", 1'b0);
      wr_op(A_ST, 32'hDEAD_BEEF);
      wr_op(A_OUT, 32'hFFFF_FFFF);
      rd_chk("t6_systick", A_ST, st_model);
      rd_chk("t6_out_window", A_OUT, 32'h0);
      rd_chk("t6_unmapped", A_1C, 32'h0);
      rd_chk("t6_th", A_TH, 32'h0);
      rd_chk("t6_tl", A_TL, 32'h0000_1235);
      rd_chk("t6_tcon", A_TCON, 32'h0);
      exp_q.push_back(32'h0);
      bus_if.addr = A_TL;
      bus_if.rd   = 1'b0;
      #1;
      compare("t6_rd_low", bus_if.rdata);

      // 7: reset while pending
      wr_op(A_TH, 32'h55);
      wr_op(A_TCON, 32'h7);
      irq_chk("t7_irq_sw", 1'b1);
      cyc(3);
      rd_chk("t7_tl_count", A_TL, 32'h0000_1238);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      irq_chk("t7_irq_rst", 1'b0);
      rd_chk("t7_th", A_TH, 32'h0);
      rd_chk("t7_tl", A_TL, 32'h0);
      rd_chk("t7_tcon", A_TCON, 32'h0);
      rd_chk("t7_systick", A_ST, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
